// File: rtl/mips_mc_controller_pkg.sv
// mips_decls_p: opcode/funct encodings, controller state and ALU-op types for the multicycle MIPS core
package mips_decls_p;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    F_ADD = 6'h20,
    F_SUB = 6'h22,
    F_AND = 6'h24,
    F_OR  = 6'h25,
    F_SLT = 6'h2A
  } funct_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_FAULT
  } mc_state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_controller_aludec.sv
// mips_mc_aludec: maps the FSM's ALU operation and the R-type funct field to an ALU control code
module mips_mc_aludec
  import mips_decls_p::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        illegal
);

  // illegal is only meaningful when the funct field is being decoded
  always_comb begin
    illegal = 1'b0;
    alucontrol = ALU_ADD;
    if (aluop == ALUOP_SUB)
      alucontrol = ALU_SUB;
    else if (aluop == ALUOP_FUNCT)
      case (funct)
        F_ADD:   alucontrol = ALU_ADD;
        F_SUB:   alucontrol = ALU_SUB;
        F_AND:   alucontrol = ALU_AND;
        F_OR:    alucontrol = ALU_OR;
        F_SLT:   alucontrol = ALU_SLT;
        default: illegal = 1'b1;
      endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: Moore control FSM for the multicycle MIPS datapath with mem_ready wait states and timeout fault.
// Optional: define MIPS_MC_BNE_EN to accept bne (opcode 6'h05) as a branch-on-not-equal.
module mips_mc_controller
  import mips_decls_p::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TCNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        memwrite,
  output logic        iord,
  output logic        irwrite,
  output logic        pcen,
  output logic        regwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic        fault
);

  mc_state_t state_q, state_d;
  logic [TCNT_W-1:0] cnt_q, cnt_d;
  aluop_t aluop;
  logic pcwrite, branch, taken, illegal_funct, mem_state, timeout;

  mips_mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol),
    .illegal    (illegal_funct)
  );

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout   = mem_state && !mem_ready && (cnt_q == TCNT_W'(MEM_TIMEOUT));
  assign fault     = (state_q == S_FAULT);
  assign pcen      = pcwrite | (branch & taken);

`ifdef MIPS_MC_BNE_EN
  logic bne_q, bne_d;
  assign taken = zero ^ bne_q;
`else
  assign taken = zero;
`endif

  // wait counter only runs while a memory access is stalled; any completion or non-memory state clears it
  always_comb cnt_d = (mem_state && !mem_ready && !timeout) ? cnt_q + 1'b1 : '0;

  // next-state sequencing; completion of a memory access wins over its timeout
  always_comb begin
    state_d = state_q;
`ifdef MIPS_MC_BNE_EN
    bne_d = bne_q;
`endif
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FAULT;
        endcase
`ifdef MIPS_MC_BNE_EN
        bne_d = (opcode == OP_BNE);
`endif
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : timeout ? S_FAULT : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : timeout ? S_FAULT : S_MEMWR;
      S_EXECUTE: state_d = illegal_funct ? S_FAULT : S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode; FETCH's IR/PC strobes wait for mem_ready and are held off during reset
  always_comb begin
    mem_req = 1'b0;
    memwrite = 1'b0;
    iord = 1'b0;
    irwrite = 1'b0;
    pcwrite = 1'b0;
    branch = 1'b0;
    regwrite = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    alusrca = 1'b0;
    alusrcb = SRCB_B;
    pcsrc = PCSRC_ALU;
    aluop = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready & reset_n;
        pcwrite = mem_ready & reset_n;
      end
      S_DECODE:  alusrcb = SRCB_IMM2;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        iord = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        pcsrc = PCSRC_ALUOUT;
        branch = 1'b1;
      end
      S_ADDIWB:  regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // state, wait counter and decoded branch type
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q <= '0;
`ifdef MIPS_MC_BNE_EN
      bne_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
`ifdef MIPS_MC_BNE_EN
      bne_q <= bne_d;
`endif
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: directed and randomized checks of the multicycle controller against an instruction-phase model
module tb_mips_mc_controller;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic [5:0] opcode = 6'h23;
  logic [5:0] funct = 6'h20;
  logic mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, fault;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_mc_controller #(.MEM_TIMEOUT(TO), .TCNT_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .fault      (fault)
  );

  typedef enum int {C_LW, C_SW, C_R, C_ADDI, C_BEQ, C_BNE, C_J, C_BAD} cls_t;

  // model: which cycle of the current instruction we are in, how long memory has stalled, sticky fault
  int m_phase = 0;
  int m_wait = 0;
  bit m_fault = 1'b0;
  cls_t m_cls = C_BAD;

  function automatic cls_t classify(logic [5:0] op);
    case (op)
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h00: return C_R;
      6'h08: return C_ADDI;
      6'h04: return C_BEQ;
      6'h02: return C_J;
`ifdef MIPS_MC_BNE_EN
      6'h05: return C_BNE;
`endif
      default: return C_BAD;
    endcase
  endfunction

  function automatic int ilen(cls_t c);
    case (c)
      C_LW: return 5;
      C_SW, C_R, C_ADDI: return 4;
      default: return 3;
    endcase
  endfunction

  // {illegal, alucontrol}
  function automatic logic [3:0] fdec(logic [5:0] f);
    case (f)
      6'h20: return 4'b0010;
      6'h22: return 4'b0110;
      6'h24: return 4'b0000;
      6'h25: return 4'b0001;
      6'h2A: return 4'b0111;
      default: return 4'b1010;
    endcase
  endfunction

  function automatic logic [16:0] expect_out();
    logic mreq = 0, mw = 0, io = 0, irw = 0, pe = 0, rw = 0, rd = 0, mtr = 0, sa = 0, fl = 0;
    logic [1:0] sb = 2'b00, ps = 2'b00;
    logic [2:0] ac = 3'b010;
    logic [3:0] fd;
    if (!reset_n) begin
      mreq = 1;
      sb = 2'b01;
    end else if (m_fault) fl = 1;
    else case (m_phase)
      0: begin mreq = 1; sb = 2'b01; irw = mem_ready; pe = mem_ready; end
      1: sb = 2'b11;
      2: case (m_cls)
        C_LW, C_SW, C_ADDI: begin sa = 1; sb = 2'b10; end
        C_R: begin sa = 1; fd = fdec(funct); ac = fd[2:0]; end
        C_BEQ: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = zero; end
        C_BNE: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = ~zero; end
        C_J: begin ps = 2'b10; pe = 1; end
        default: ;
      endcase
      3: case (m_cls)
        C_LW: begin mreq = 1; io = 1; end
        C_SW: begin mreq = 1; io = 1; mw = 1; end
        C_R: begin rw = 1; rd = 1; end
        C_ADDI: rw = 1;
        default: ;
      endcase
      4: begin rw = 1; mtr = 1; end
      default: ;
    endcase
    return {mreq, mw, io, irw, pe, rw, rd, mtr, sa, sb, ps, ac, fl};
  endfunction

  task automatic advance();
    bit memph;
    logic [3:0] fd;
    if (!reset_n) begin
      m_phase = 0;
      m_wait = 0;
      m_fault = 0;
      return;
    end
    if (m_fault) return;
    memph = (m_phase == 0) || (m_phase == 3 && (m_cls == C_LW || m_cls == C_SW));
    if (memph && !mem_ready) begin
      if (m_wait == TO) m_fault = 1;
      else m_wait++;
      return;
    end
    m_wait = 0;
    if (m_phase == 1) begin
      m_cls = classify(opcode);
      if (m_cls == C_BAD) begin m_fault = 1; return; end
    end
    fd = fdec(funct);
    if (m_phase == 2 && m_cls == C_R && fd[3]) begin m_fault = 1; return; end
    m_phase++;
    if (m_phase == ilen(m_cls)) m_phase = 0;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // every cycle: outputs against the model, then step the model with this cycle's inputs
  initial forever begin
    @(negedge clk);
    chk($sformatf("cycle_outputs ph%0d cls%0d flt%0d", m_phase, m_cls, m_fault),
        {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, alusrcb, pcsrc, alucontrol, fault},
        expect_out());
    advance();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    cyc();
    reset_n = 0;
    cyc();
    reset_n = 1;
  endtask

  int pc_cnt;
  int stall;

  initial begin
    mem_ready = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_req", mem_req, 1);
    chk("rst_irwrite", irwrite, 0);
    chk("rst_pcen", pcen, 0);
    chk("rst_alusrcb", alusrcb, 2'b01);
    chk("rst_alucontrol", alucontrol, 3'b010);
    chk("rst_fault", fault, 0);
    // lw, no wait states
    cyc();
    reset_n = 1;
    pc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      pc_cnt += int'(pcen);
      if (i == 4) begin
        chk("lw_wb_regwrite", regwrite, 1);
        chk("lw_wb_memtoreg", memtoreg, 1);
        chk("lw_wb_regdst", regdst, 0);
      end else chk("lw_regwrite_early", regwrite, 0);
      cyc();
    end
    chk("lw_pcen_pulses", pc_cnt, 1);
    // fetch with three wait cycles
    opcode = 6'h08;
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      #1;
      chk("fwait_mem_req", mem_req, 1);
      chk("fwait_iord", iord, 0);
      chk("fwait_irwrite", irwrite, (i == 3) ? 1 : 0);
      chk("fwait_pcen", pcen, (i == 3) ? 1 : 0);
      cyc();
    end
    repeat (3) cyc();
    // sw timing out in MEMWR
    opcode = 6'h2B;
    repeat (3) cyc();
    mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("memwr_wait_fault", fault, 0);
      chk("memwr_wait_memwrite", memwrite, 1);
      cyc();
    end
    #1;
    chk("timeout_fault", fault, 1);
    chk("timeout_enables", {mem_req, irwrite, pcen, regwrite}, 4'b0000);
    mem_ready = 1;
    cyc();
    #1;
    chk("fault_sticky", fault, 1);
    cyc();
    reset_n = 0;
    #1;
    chk("fault_cleared_by_reset", fault, 0);
    cyc();
    reset_n = 1;
    #1;
    chk("post_reset_fetch", {mem_req, iord}, 2'b10);
    // beq taken then not taken
    opcode = 6'h04;
    zero = 1;
    cyc();
    cyc();
    #1;
    chk("beq_taken_pcen", pcen, 1);
    chk("beq_pcsrc", pcsrc, 2'b01);
    chk("beq_alucontrol", alucontrol, 3'b110);
    cyc();
    zero = 0;
    cyc();
    cyc();
    #1;
    chk("beq_nottaken_pcen", pcen, 0);
    chk("beq_nt_pcsrc", pcsrc, 2'b01);
    chk("beq_nt_alucontrol", alucontrol, 3'b110);
    cyc();
    // R-type slt, then an illegal funct
    opcode = 6'h00;
    funct = 6'h2A;
    cyc();
    cyc();
    #1;
    chk("slt_alucontrol", alucontrol, 3'b111);
    cyc();
    #1;
    chk("slt_wb", {regwrite, regdst, memtoreg}, 3'b110);
    cyc();
    funct = 6'h3F;
    repeat (3) cyc();
    #1;
    chk("bad_funct_fault", fault, 1);
    rst_pulse();
    // bne with zero clear
    opcode = 6'h05;
    zero = 0;
    cyc();
    cyc();
    #1;
`ifdef MIPS_MC_BNE_EN
    chk("bne_pcen", pcen, 1);
    chk("bne_fault", fault, 0);
`else
    chk("bne_illegal_fault", fault, 1);
`endif
    rst_pulse();
    // reset in the middle of a stalled MEMRD
    opcode = 6'h23;
    cyc();
    cyc();
    cyc();
    mem_ready = 0;
    cyc();
    #1;
    chk("memrd_iord", iord, 1);
    #2;
    reset_n = 0;
    #1;
    chk("async_rst_fetch", {mem_req, iord, regwrite}, 3'b100);
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("rst_no_regwrite", regwrite, 0);
    end
    cyc();
    reset_n = 1;
    // randomized traffic
    stall = 0;
    for (int n = 0; n < 4000; n++) begin
      cyc();
      reset_n = !((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0);
      if (m_phase == 0) begin
        case ($urandom_range(0, 7))
          0: opcode = 6'h23;
          1: opcode = 6'h2B;
          2: opcode = 6'h00;
          3: opcode = 6'h04;
          4: opcode = 6'h08;
          5: opcode = 6'h02;
          6: opcode = 6'h05;
          default: opcode = 6'($urandom);
        endcase
        case ($urandom_range(0, 9))
          0: funct = 6'h20;
          1: funct = 6'h22;
          2, 3: funct = 6'h24;
          4, 5: funct = 6'h25;
          6, 7: funct = 6'h2A;
          default: funct = 6'($urandom);
        endcase
      end
      zero = 1'($urandom_range(0, 1));
      if (stall > 0) begin
        mem_ready = 0;
        stall--;
      end else begin
        if ($urandom_range(0, 7) == 0) stall = $urandom_range(1, 7);
        mem_ready = ($urandom_range(0, 3) != 0);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
